transmitter: RTL and testbench
==============================

# transmitter

Packet-level UART transmitter for the dual-image upgrade path. On a `start` pulse it serialises a packet (command byte, length byte, then `len_tx` payload bytes read from an external synchronous RAM) onto `txd`. It sits between the upgrade controller, which fills the RAM and issues commands, and the board UART pin.

## Interface
Parameters:
- `CLOCK`, 10_000_000: `clk` frequency in Hz.
- `BAUD`, 1_000_000: bit rate in bit/s.
- `PARITY`, "NO": "NO", "EVEN" or "ODD"; when not "NO", one parity bit follows the data bits.
- `FIRST_BIT`, "LSB": data bit order on the line, "LSB" or "MSB".
- `NUMBER`, 256: payload RAM depth; the address width is `$clog2(NUMBER)`.
- `PAUSE`, 2: idle (high) bit-times inserted after each stop bit before the next start bit.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `txd`  out  1  serial line, idle high.
- `start`  in  1  single-cycle request to send a packet.
- `cmd_tx`  in  8  command byte, sampled with `start`.
- `len_tx`  in  8  payload byte count, sampled with `start`.
- `rd_data`  in  8  RAM read data, valid one `rd_clock` edge after `rd_addr`.
- `rd_addr`  out  `$clog2(NUMBER)`  RAM read address.
- `rd_clock`  out  1  RAM read clock; this is `clk` passed through.

## Operation
- Reset state: `txd`=1, `rd_addr`=0, FSM in IDLE, internal counters at 0.
- Packet order: `cmd_tx`, then `len_tx`, then RAM[0] … RAM[len_tx-1].
  - With `len_tx`=0, only the two header bytes are sent.
  - If `len_tx` > `NUMBER`, addresses wrap modulo `NUMBER`.
- Byte frame:
  - 1 start bit (0).
  - 8 data bits, ordered per `FIRST_BIT`.
  - Optional parity bit: EVEN means the total count of ones over data and parity is even; ODD means it is odd.
  - 1 stop bit (1).
  - `PAUSE` bit-times high before the next byte. Every byte gets this pause, including the last one.
- FSM states: IDLE → HDR_CMD → HDR_LEN → (DATA)* → IDLE.
  - In IDLE, `start`=1 latches `cmd_tx`/`len_tx` and moves to HDR_CMD.
  - Each state sends one byte; the FSM advances when that byte's pause completes.
  - In DATA, a down-counter of the remaining bytes is kept, and `rd_addr` increments after each payload byte is loaded.
- `start` is ignored while not in IDLE. Changes to `cmd_tx`/`len_tx` after latching have no effect on the packet in progress.
- Payload prefetch: `rd_addr` is set at least 2 clocks before a payload byte is loaded into the shifter, so the RAM's one-cycle read latency is always covered.

## Timing
- Bit period: `BIT = round(CLOCK/BAUD)` clocks, which is 10 at the defaults. Every bit, including each pause bit, lasts exactly `BIT` clocks.
- Start latency: `txd` falls on the first `clk` edge after the edge on which `start` is sampled high in IDLE.
- Per-byte duration: (10 + parity + `PAUSE`) × `BIT` clocks. At the defaults that is 12 µs: a 10 µs frame plus a 2 µs gap.
- Packet duration: (2 + `len_tx`) × per-byte duration. The FSM returns to IDLE after the final pause, and a `start` on the next cycle is accepted.
- Asynchronous reset mid-packet:
  - `txd` goes high immediately, and the FSM returns to IDLE.
  - No partial byte resumes after reset release.

## Structure
- Shared package `transmitter_pkg`: FSM state enum; parity and bit-order encodings; a bit-period function `bit_clocks(CLOCK, BAUD)`.
- Sub-module `uart_tx_byte`, the byte serialiser:
  - Inputs: `load`, `byte`.
  - Outputs: `txd` and a `done` pulse at the end of the pause.
  - It owns the baud counter, bit counter, parity generation and bit ordering.
- The top level holds the packet FSM, the length counter and `rd_addr`.

## Test plan
1. Reset and idle: hold `reset`=0, then release with `start` never asserted → `txd` stays 1 and `rd_addr`=0 throughout.
2. Basic packet: defaults, `cmd_tx`=0x43, `len_tx`=3, RAM = {0xA5,0x3C,0x0F}, one `start` pulse → decoded bytes 43,03,A5,3C,0F. Each frame is 10 µs; the gap between a stop bit ending and the next start bit is 2 µs; `start`→first `txd` fall is 1 clk.
3. Zero length: `len_tx`=0, `cmd_tx`=0x55 → only bytes 55,00 are sent, and `rd_addr` never leaves 0.
4. Options: `PARITY`="EVEN", `FIRST_BIT`="MSB", `cmd_tx`=0x07 → data bits are sent 0,0,0,0,0,1,1,1, followed by parity 1; the frame is 11 µs.
5. Busy protection: pulse `start` again with `cmd_tx`=0x99 mid-packet → it is ignored, and the packet content is unchanged.
6. Reset mid-byte: assert `reset` during a payload byte → `txd`=1 asynchronously. After release, a new `start` sends a full, correct packet from `rd_addr`=0.

Source files
------------

// File: rtl/transmitter_pkg.sv
// transmitter_pkg: packet FSM states, line-option encodings and bit-period helper
package transmitter_pkg;
  typedef enum logic [1:0] {IDLE, HDR_CMD, HDR_LEN, DATA} state_e;
  typedef enum logic [1:0] {PAR_NO, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic {LSB_FIRST, MSB_FIRST} order_e;
  function automatic int bit_clocks(input int clock, input int baud);
    return (clock + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: shifts one framed byte (start, data, parity, stop, pause) onto the line
module uart_tx_byte
  import transmitter_pkg::*;
#(
  parameter int    CLOCK     = 10_000_000,
  parameter int    BAUD      = 1_000_000,
  parameter string PARITY    = "NO",
  parameter string FIRST_BIT = "LSB",
  parameter int    PAUSE     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_txd,
  output logic       o_done
);
  localparam parity_e PM = (PARITY == "EVEN") ? PAR_EVEN : (PARITY == "ODD") ? PAR_ODD : PAR_NO;
  localparam order_e OM = (FIRST_BIT == "MSB") ? MSB_FIRST : LSB_FIRST;
  localparam int BIT = bit_clocks(CLOCK, BAUD);
  localparam int NB = 10 + ((PM == PAR_NO) ? 0 : 1) + PAUSE;
  localparam int BW = $clog2(BIT + 1);
  localparam int CW = $clog2(NB + 1);
  logic [7:0]    w_ord;
  logic [NB-1:0] w_frame;
  logic [NB-1:0] r_shift;
  logic [BW-1:0] r_baud;
  logic [CW-1:0] r_bits;
  logic          r_busy;
  logic          r_txd;
  // frame bit 0 goes out first; everything above stop/parity is pause (high)
  always_comb begin
    w_ord = (OM == MSB_FIRST) ? {i_byte[0], i_byte[1], i_byte[2], i_byte[3],
                                 i_byte[4], i_byte[5], i_byte[6], i_byte[7]} : i_byte;
    w_frame = '1;
    w_frame[0] = 1'b0;
    w_frame[8:1] = w_ord;
    w_frame[9] = (PM == PAR_NO) ? 1'b1 : ((^i_byte) ^ (PM == PAR_ODD));
  end
  assign o_txd  = r_txd;
  assign o_done = r_busy && (r_baud == '0) && (r_bits == '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
      r_shift <= '1;
      r_baud  <= '0;
      r_bits  <= '0;
    end else if (i_load) begin
      r_busy  <= 1'b1;
      r_txd   <= w_frame[0];
      r_shift <= {1'b1, w_frame[NB-1:1]};
      r_baud  <= BW'(BIT - 1);
      r_bits  <= CW'(NB - 1);
    end else if (r_busy) begin
      if (r_baud != '0) r_baud <= r_baud - 1'b1;
      else if (r_bits != '0) begin
        r_bits  <= r_bits - 1'b1;
        r_baud  <= BW'(BIT - 1);
        r_txd   <= r_shift[0];
        r_shift <= {1'b1, r_shift[NB-1:1]};
      end else r_busy <= 1'b0;
    end
endmodule

// File: rtl/transmitter.sv
// transmitter: sends cmd, len and len payload bytes from a sync RAM as UART frames
module transmitter
  import transmitter_pkg::*;
#(
  parameter int    CLOCK     = 10_000_000,
  parameter int    BAUD      = 1_000_000,
  parameter string PARITY    = "NO",
  parameter string FIRST_BIT = "LSB",
  parameter int    NUMBER    = 256,
  parameter int    PAUSE     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      txd,
  input  logic                      start,
  input  logic [7:0]                cmd_tx,
  input  logic [7:0]                len_tx,
  input  logic [7:0]                rd_data,
  output logic [$clog2(NUMBER)-1:0] rd_addr,
  output logic                      rd_clock
);
  localparam int AW = $clog2(NUMBER);
  state_e        r_state;
  state_e        w_next;
  logic          r_kick;
  logic [7:0]    r_cmd;
  logic [7:0]    r_remain;
  logic [AW-1:0] r_addr;
  logic [7:0]    w_byte;
  logic          w_load;
  logic          w_done;
  uart_tx_byte #(
    .CLOCK(CLOCK), .BAUD(BAUD), .PARITY(PARITY), .FIRST_BIT(FIRST_BIT), .PAUSE(PAUSE)
  ) u_byte (
    .clk(clk), .reset(reset), .i_load(w_load), .i_byte(w_byte), .o_txd(txd), .o_done(w_done)
  );
  assign rd_clock = clk;
  assign rd_addr  = r_addr;
  // the next byte is loaded on the very edge the previous pause ends, so bytes abut exactly
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? HDR_CMD : IDLE) :
             !w_done ? r_state :
             (r_state == HDR_CMD) ? HDR_LEN :
             (r_remain == 8'd0) ? IDLE : DATA;
    w_byte = (w_next == HDR_CMD) ? r_cmd : (w_next == HDR_LEN) ? r_remain : rd_data;
    w_load = r_kick || (w_done && (w_next != IDLE));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_kick   <= 1'b0;
      r_cmd    <= '0;
      r_remain <= '0;
      r_addr   <= '0;
    end else begin
      r_state <= w_next;
      r_kick  <= (r_state == IDLE) && start;
      if ((r_state == IDLE) && start) begin
        r_cmd    <= cmd_tx;
        r_remain <= len_tx;
      end else if (w_load && (w_next == DATA)) r_remain <= r_remain - 8'd1;
      if (w_next == IDLE) r_addr <= '0;
      else if (w_load && (w_next == DATA)) r_addr <= (r_addr == AW'(NUMBER - 1)) ? '0 : r_addr + 1'b1;
    end
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: default instance plus an EVEN/MSB/4-deep instance against a bit-stream model
module tb_transmitter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] cmd_a = '0, len_a = '0, cmd_b = '0, len_b = '0;
  logic [7:0] rdd_a = '0, rdd_b = '0;
  logic [7:0] addr_a;
  logic [1:0] addr_b;
  logic       txd_a, txd_b, rclk_a, rclk_b;
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [4];
  logic       cap [$];
  int         tests = 0, fails = 0, max_addr = 0;

  always #5 clk = ~clk;
  always @(posedge rclk_a) rdd_a <= ram_a[addr_a];
  always @(posedge rclk_b) rdd_b <= ram_b[addr_b];

  transmitter u_a (
    .clk(clk), .reset(reset), .txd(txd_a), .start(start_a), .cmd_tx(cmd_a), .len_tx(len_a),
    .rd_data(rdd_a), .rd_addr(addr_a), .rd_clock(rclk_a)
  );
  transmitter #(.PARITY("EVEN"), .FIRST_BIT("MSB"), .NUMBER(4)) u_b (
    .clk(clk), .reset(reset), .txd(txd_b), .start(start_b), .cmd_tx(cmd_b), .len_tx(len_b),
    .rd_data(rdd_b), .rd_addr(addr_b), .rd_clock(rclk_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: packet = byte list; each byte = start, 8 data, [even parity], stop, 2 pause; 10 clk per bit
  task automatic run_packet(input bit opt, input logic [7:0] cmd, input logic [7:0] len,
                            input int busy_at, input string tag);
    logic [7:0] bytes [$];
    bit         eq [$];
    logic [7:0] b;
    int         nb, n, mism, a;
    nb = opt ? 13 : 12;
    bytes = {cmd, len};
    for (int k = 0; k < int'(len); k++) bytes.push_back(opt ? ram_b[k % 4] : ram_a[k % 256]);
    foreach (bytes[k]) begin
      eq.push_back(1'b0);
      for (int j = 0; j < 8; j++) eq.push_back(opt ? bytes[k][7-j] : bytes[k][j]);
      if (opt) eq.push_back(^bytes[k]);
      repeat (3) eq.push_back(1'b1);
    end
    n = eq.size() * 10;
    @(posedge clk); #1;
    if (opt) begin start_b = 1'b1; cmd_b = cmd; len_b = len; end
    else begin start_a = 1'b1; cmd_a = cmd; len_a = len; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    check({tag, " latency idle"}, 32'(opt ? txd_b : txd_a), 32'(1'b1));
    cap.delete();
    max_addr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap.push_back(opt ? txd_b : txd_a);
      a = opt ? int'(addr_b) : int'(addr_a);
      if (a > max_addr) max_addr = a;
      if (i == busy_at) begin
        if (opt) begin start_b = 1'b1; cmd_b = 8'h99; len_b = 8'd9; end
        else begin start_a = 1'b1; cmd_a = 8'h99; len_a = 8'd9; end
      end
      if (i == busy_at + 1) begin start_a = 1'b0; start_b = 1'b0; end
    end
    mism = 0;
    for (int i = 0; i < n; i++) if (cap[i] !== eq[i / 10]) mism++;
    check({tag, " waveform mismatches"}, 32'(mism), 32'd0);
    foreach (bytes[k]) begin
      for (int j = 0; j < 8; j++) b[opt ? 7 - j : j] = cap[(k * nb + 1 + j) * 10 + 5];
      check($sformatf("%s byte%0d", tag, k), 32'(b), 32'(bytes[k]));
    end
  endtask

  initial begin
    int bad;
    logic [8:0] ob;
    for (int i = 0; i < 256; i++) ram_a[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) ram_b[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("reset txd_a", 32'(txd_a), 32'(1'b1));
    check("reset addr_a", 32'(addr_a), 32'd0);
    check("reset txd_b", 32'(txd_b), 32'(1'b1));
    check("reset addr_b", 32'(addr_b), 32'd0);
    reset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || addr_a !== 8'd0 || txd_b !== 1'b1) bad++;
    end
    check("idle after release", 32'(bad), 32'd0);

    ram_a[0] = 8'hA5; ram_a[1] = 8'h3C; ram_a[2] = 8'h0F;
    run_packet(1'b0, 8'h43, 8'd3, -1, "basic");
    run_packet(1'b0, 8'h55, 8'd0, -1, "zero_len");
    check("zero_len addr max", 32'(max_addr), 32'd0);
    run_packet(1'b1, 8'h07, 8'd0, -1, "opt");
    for (int j = 0; j < 9; j++) ob[8 - j] = cap[(1 + j) * 10 + 5];
    check("opt msb bits+parity", 32'(ob), 32'(9'b000001111));
    check("opt stop bit", 32'(cap[105]), 32'(1'b1));
    run_packet(1'b1, 8'hC1, 8'd6, -1, "wrap");
    run_packet(1'b0, 8'h12, 8'd2, 300, "busy");

    ram_a[0] = 8'h00;
    @(posedge clk); #1;
    start_a = 1'b1; cmd_a = 8'h3C; len_a = 8'd4;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (253) @(negedge clk);
    check("pre-reset txd low", 32'(txd_a), 32'(1'b0));
    check("pre-reset addr", 32'(addr_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset txd", 32'(txd_a), 32'(1'b1));
    check("async reset addr", 32'(addr_a), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || addr_a !== 8'd0) bad++;
    end
    check("no resume after reset", 32'(bad), 32'd0);
    run_packet(1'b0, 8'hA7, 8'd3, -1, "post_reset");

    for (int r = 0; r < 4; r++) begin
      run_packet(1'b0, 8'($urandom), 8'($urandom_range(0, 12)), -1, $sformatf("rand_a%0d", r));
      run_packet(1'b1, 8'($urandom), 8'($urandom_range(0, 9)), -1, $sformatf("rand_b%0d", r));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
